rom_reader: RTL and testbench

ROM_READER -- requirements
Module: rom_reader

---
 rtl/rom_reader.sv | 89 ++++++++
 tb/tb_rom_reader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_reader.sv
// rom_reader: burst reader for an asynchronous parallel ROM with a fixed access wait,
// handing each captured word to a valid/ready consumer with back-pressure.
module rom_reader #(
   parameter int AWIDTH      = 16,
   parameter int DWIDTH      = 8,
   parameter int WAIT_CYCLES = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [AWIDTH-1:0] cmd_addr,
   input  logic [7:0]        cmd_len,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DWIDTH-1:0] rd_data,
   output logic              rd_last,
   output logic              busy,
   output logic [AWIDTH-1:0] Address,
   input  logic [DWIDTH-1:0] Data,
   output logic              _CS,
   output logic              _OE
);
   localparam logic [7:0] RELOAD = 8'(WAIT_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, ACCESS, DRAIN} state_t;
   state_t state, state_nx;
   logic [7:0] cnt;
   logic [8:0] rem;
   logic accept, expiry, pop, capture, final_word;
   always_comb begin
      accept     = state == IDLE && cmd_valid;
      expiry     = state == ACCESS && cnt == 8'd0;
      pop        = rd_valid && rd_ready;
      capture    = expiry && (!rd_valid || rd_ready);
      final_word = rem == 9'd1;
      state_nx   = state;
      case (state)
         IDLE:    state_nx = accept ? ACCESS : IDLE;
         ACCESS:  state_nx = (capture && final_word) ? DRAIN : ACCESS;
         DRAIN:   state_nx = pop ? IDLE : DRAIN;
         default: state_nx = IDLE;
      endcase
   end
   assign cmd_ready = state == IDLE;
   assign busy      = state != IDLE;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Address  <= '0;
         _CS      <= 1'b1;
         _OE      <= 1'b1;
         cnt      <= 8'd0;
         rem      <= 9'd0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
      end else begin
         if (accept) begin
            Address <= cmd_addr;
            _CS     <= 1'b0;
            _OE     <= 1'b0;
            cnt     <= RELOAD;
            rem     <= (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
         end
         // an expired counter parks at 0, which is also the stall condition
         if (state == ACCESS && !capture)
            cnt <= (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
         if (capture) begin
            rd_data  <= Data;
            rd_valid <= 1'b1;
            rd_last  <= final_word;
            rem      <= rem - 9'd1;
            if (final_word) begin
               _CS <= 1'b1;
               _OE <= 1'b1;
            end else begin
               Address <= Address + AWIDTH'(1);
               cnt     <= RELOAD;
            end
         end else if (pop) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_rom_reader.sv
// tb_rom_reader: directed scenarios for rom_reader against a behavioural 45ns ROM.
module tb_rom_reader;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [15:0] cmd_addr = '0;
   logic [7:0]  cmd_len = '0;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic [7:0]  rd_data;
   logic        rd_last;
   logic        busy;
   logic [15:0] Address;
   logic [7:0]  rom_data;
   logic        cs_n, oe_n;
   int          n_checks = 0;
   int          n_fail = 0;

   rom_reader #(.AWIDTH(16), .DWIDTH(8), .WAIT_CYCLES(5)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_data(rd_data), .rd_last(rd_last), .busy(busy), .Address(Address),
      .Data(rom_data), ._CS(cs_n), ._OE(oe_n)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_val(input logic [15:0] a);
      return (a == 16'h0010) ? 8'hA5 : (a[7:0] ^ a[15:8] ^ 8'h5A);
   endfunction

   always @(Address) rom_data <= #45 rom_val(Address);

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] a, input logic [7:0] l);
      cmd_addr  = a;
      cmd_len   = l;
      cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
   endtask

   // Consume n words starting at base; first>0 also checks the cycle each word appears.
   task automatic collect(input logic [15:0] base, input int n, input int first);
      int got = 0;
      logic [15:0] a;
      for (int c = 1; c <= 5 * n + 20 && got < n; c++) begin
         tick;
         if (rd_valid && rd_ready) begin
            a = base + 16'(got);
            n_checks++;
            if (rd_data !== rom_val(a)) begin
               n_fail++;
               $display("FAIL word_data[%0d] addr %h: got %h expected %h", got, a, rd_data, rom_val(a));
            end
            n_checks++;
            if (rd_last !== (got == n - 1)) begin
               n_fail++;
               $display("FAIL word_last[%0d]: got %b expected %b", got, rd_last, got == n - 1);
            end
            if (first > 0) begin
               n_checks++;
               if (c != first + 5 * got) begin
                  n_fail++;
                  $display("FAIL word_time[%0d]: got cycle %0d expected %0d", got, c, first + 5 * got);
               end
            end
            got++;
         end
      end
      n_checks++;
      if (got != n) begin
         n_fail++;
         $display("FAIL word_count base %h: got %0d expected %0d", base, got, n);
      end
   endtask

   task automatic check_idle(input string name);
      tick;
      tick;
      n_checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || cs_n !== 1'b1 || oe_n !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_idle: busy=%b cmd_ready=%b cs=%b oe=%b expected 0 1 1 1", name, busy, cmd_ready, cs_n, oe_n);
      end
   endtask

   task automatic test_reset;
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (cs_n !== 1'b1 || oe_n !== 1'b1 || rd_valid !== 1'b0 || rd_last !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: cs=%b oe=%b rd_valid=%b rd_last=%b expected 1 1 0 0", cs_n, oe_n, rd_valid, rd_last);
      end
      n_checks++;
      if (Address !== 16'h0000 || rd_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_regs: Address=%h rd_data=%h expected 0000 00", Address, rd_data);
      end
      n_checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_status: busy=%b cmd_ready=%b expected 0 1", busy, cmd_ready);
      end
      tick;
      reset = 1'b0;
   endtask

   task automatic test_single;
      rd_ready = 1'b1;
      send(16'h0010, 8'd1);
      n_checks++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0 || cs_n !== 1'b0 || oe_n !== 1'b0 || Address !== 16'h0010) begin
         n_fail++;
         $display("FAIL single_accept: busy=%b cmd_ready=%b cs=%b oe=%b Address=%h expected 1 0 0 0 0010",
                  busy, cmd_ready, cs_n, oe_n, Address);
      end
      repeat (4) tick;
      n_checks++;
      if (rd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_early: rd_valid=%b expected 0 four edges after accept", rd_valid);
      end
      tick;
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || rd_last !== 1'b1) begin
         n_fail++;
         $display("FAIL single_word: rd_valid=%b rd_data=%h rd_last=%b expected 1 a5 1", rd_valid, rd_data, rd_last);
      end
      n_checks++;
      if (cs_n !== 1'b1 || oe_n !== 1'b1) begin
         n_fail++;
         $display("FAIL single_deselect: cs=%b oe=%b expected 1 1", cs_n, oe_n);
      end
      tick;
      n_checks++;
      if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== 8'hA5) begin
         n_fail++;
         $display("FAIL single_pop: rd_valid=%b rd_last=%b rd_data=%h expected 0 0 a5", rd_valid, rd_last, rd_data);
      end
      tick;
      n_checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_ready: cmd_ready=%b busy=%b expected 1 0", cmd_ready, busy);
      end
   endtask

   task automatic test_wrap;
      rd_ready = 1'b1;
      send(16'hFFFE, 8'd4);
      collect(16'hFFFE, 4, 5);
      check_idle("wrap");
   endtask

   task automatic test_backpressure;
      rd_ready = 1'b0;
      send(16'h0300, 8'd3);
      repeat (5) tick;
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== rom_val(16'h0300) || rd_last !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_word0: rd_valid=%b rd_data=%h rd_last=%b expected 1 %h 0",
                  rd_valid, rd_data, rd_last, rom_val(16'h0300));
      end
      for (int k = 0; k < 20; k++) begin
         tick;
         n_checks++;
         if (rd_valid !== 1'b1 || rd_data !== rom_val(16'h0300) || Address !== 16'h0301 || cs_n !== 1'b0 || oe_n !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: rd_valid=%b rd_data=%h Address=%h cs=%b oe=%b expected 1 %h 0301 0 0",
                     k, rd_valid, rd_data, Address, cs_n, oe_n, rom_val(16'h0300));
         end
      end
      rd_ready = 1'b1;
      collect(16'h0301, 2, 1);
      check_idle("bp");
   endtask

   task automatic test_full;
      rd_ready = 1'b1;
      send(16'h1200, 8'd0);
      collect(16'h1200, 256, 5);
      check_idle("full");
   endtask

   task automatic test_reset_mid;
      rd_ready = 1'b1;
      send(16'h0500, 8'd8);
      repeat (7) tick;
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (cs_n !== 1'b1 || oe_n !== 1'b1 || rd_valid !== 1'b0 || busy !== 1'b0 || Address !== 16'h0000) begin
         n_fail++;
         $display("FAIL midreset_async: cs=%b oe=%b rd_valid=%b busy=%b Address=%h expected 1 1 0 0 0000",
                  cs_n, oe_n, rd_valid, busy, Address);
      end
      tick;
      n_checks++;
      if (rd_valid !== 1'b0 || cs_n !== 1'b1 || cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_hold: rd_valid=%b cs=%b cmd_ready=%b expected 0 1 1", rd_valid, cs_n, cmd_ready);
      end
      cmd_addr  = 16'h0010;
      cmd_len   = 8'd1;
      cmd_valid = 1'b1;
      reset     = 1'b0;
      tick;
      cmd_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || Address !== 16'h0010) begin
         n_fail++;
         $display("FAIL midreset_accept: busy=%b Address=%h expected 1 0010", busy, Address);
      end
      collect(16'h0010, 1, 5);
      check_idle("midreset");
   endtask

   task automatic test_ignore_cmd;
      rd_ready  = 1'b1;
      cmd_addr  = 16'h0700;
      cmd_len   = 8'd2;
      cmd_valid = 1'b1;
      tick;
      cmd_addr = 16'h0900;
      cmd_len  = 8'd5;
      n_checks++;
      if (cmd_ready !== 1'b0 || Address !== 16'h0700) begin
         n_fail++;
         $display("FAIL ignore_busy: cmd_ready=%b Address=%h expected 0 0700", cmd_ready, Address);
      end
      collect(16'h0700, 2, 5);
      tick;
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ignore_idle: cmd_ready=%b expected 1", cmd_ready);
      end
      tick;
      cmd_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || Address !== 16'h0900) begin
         n_fail++;
         $display("FAIL ignore_next: busy=%b Address=%h expected 1 0900", busy, Address);
      end
      collect(16'h0900, 5, 5);
      check_idle("ignore");
   endtask

   initial begin
      test_reset;
      test_single;
      test_wrap;
      test_backpressure;
      test_full;
      test_reset_mid;
      test_ignore_cmd;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
